// File: rtl/score_display_n_if.sv
// Signal bundle between the game logic / VGA mux and score_display_n.
interface score_display_n_if #(
   parameter int DIGITS  = 4,
   parameter int SCORE_W = 14
);
   // Handshake: new_score is a one-cycle request that needs no ready. busy is high from the
   // accepting edge until one cycle after the display register is written. Strobes seen
   // while busy are merged into one re-sample of score when the running conversion ends.
   logic               new_score;
   logic [SCORE_W-1:0] score;
   logic [9:0]         x;
   logic [9:0]         y;
   logic [7:0]         sseg;
   logic [DIGITS-1:0]  an;
   logic               score_on;
   logic               busy;
   logic [1:0]         fsm_state;

   modport master (
      output new_score, score, x, y,
      input  sseg, an, score_on, busy, fsm_state
   );

   modport slave (
      input  new_score, score, x, y,
      output sseg, an, score_on, busy, fsm_state
   );
endinterface

// File: rtl/score_display_n.sv
// N-digit score display: iterative double-dabble BCD conversion, multiplexed seven-segment
// drive and 16x16 glyph rendering for the VGA overlay.
module numbers_rom (
   input  logic        clk,
   input  logic [11:0] addr,
   output logic        data
);
   // Glyphs are drawn from seven-segment geometry: addr = {digit, row, col}.
   function automatic logic [7:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0:    seg_code = 8'h81;
         4'd1:    seg_code = 8'hCF;
         4'd2:    seg_code = 8'h92;
         4'd3:    seg_code = 8'h86;
         4'd4:    seg_code = 8'hCC;
         4'd5:    seg_code = 8'hA4;
         4'd6:    seg_code = 8'hA0;
         4'd7:    seg_code = 8'h8F;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h84;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   logic [6:0] lit;
   logic [3:0] r;
   logic [3:0] c;
   logic       hbar;
   logic       left;
   logic       right;
   logic       upper;
   logic       lower;
   logic       pixel;

   always_comb begin
      lit   = ~seg_code(addr[11:8]) & 7'h7F;
      r     = addr[7:4];
      c     = addr[3:0];
      hbar  = (c >= 4'd3) && (c <= 4'd12);
      left  = (c == 4'd2) || (c == 4'd3);
      right = (c == 4'd12) || (c == 4'd13);
      upper = (r >= 4'd1) && (r <= 4'd8);
      lower = (r >= 4'd7) && (r <= 4'd14);
      // lit bit order is a,b,c,d,e,f,g from bit 6 down to bit 0
      pixel = (lit[6] && hbar && (r == 4'd1 || r == 4'd2))
            | (lit[0] && hbar && (r == 4'd7 || r == 4'd8))
            | (lit[3] && hbar && (r == 4'd13 || r == 4'd14))
            | (lit[1] && left && upper)
            | (lit[5] && right && upper)
            | (lit[2] && left && lower)
            | (lit[4] && right && lower);
   end

   always_ff @(posedge clk) begin
      data <= pixel;
   end
endmodule

module score_display_n #(
   parameter int DIGITS   = 4,
   parameter int SCORE_W  = 14,
   parameter int X0       = 336,
   parameter int Y0       = 16,
   parameter int MUX_BITS = 17,
   parameter int BLANK_LZ = 1
) (
   input logic             clk,
   input logic             reset,
   score_display_n_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0:    seg_code = 8'h81;
         4'd1:    seg_code = 8'hCF;
         4'd2:    seg_code = 8'h92;
         4'd3:    seg_code = 8'h86;
         4'd4:    seg_code = 8'hCC;
         4'd5:    seg_code = 8'hA4;
         4'd6:    seg_code = 8'hA0;
         4'd7:    seg_code = 8'h8F;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h84;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   // Accumulator holds every decimal digit of 2^SCORE_W-1, and at least DIGITS digits.
   localparam int ACC_D0 = (SCORE_W * 30103) / 100000 + 1;
   localparam int ACC_D  = (ACC_D0 > DIGITS) ? ACC_D0 : DIGITS;
   localparam int ACC_W  = 4 * ACC_D;
   localparam int CNT_W  = $clog2(SCORE_W + 1);
   localparam int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
   localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [SCORE_W-1:0] sh;
   logic [SCORE_W-1:0] score_lat;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_adj;
   logic [4*DIGITS-1:0] disp;
   logic               pending;
   logic               busy_r;
   logic               sat;
   logic               load_sh;
   logic               do_shift;
   logic               do_load;
   logic               pend_set;
   logic               pend_clr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_sh    = 1'b0;
      do_shift   = 1'b0;
      do_load    = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.new_score) begin
               load_sh    = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            do_shift = 1'b1;
            pend_set = bus.new_score;
            if (cnt == CNT_W'(SCORE_W - 1)) state_next = LOAD;
         end
         LOAD: begin
            do_load = 1'b1;
            // A strobe arriving during LOAD is served by the same restart as a pending one.
            if (pending || bus.new_score) begin
               load_sh    = 1'b1;
               pend_clr   = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < ACC_D; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   assign sat = (64'(score_lat) > MAX_VAL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         sh        <= '0;
         score_lat <= '0;
         acc       <= '0;
         disp      <= '0;
         pending   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= (state != IDLE) || load_sh;
         if (pend_clr)      pending <= 1'b0;
         else if (pend_set) pending <= 1'b1;
         if (load_sh) begin
            sh        <= bus.score;
            score_lat <= bus.score;
            acc       <= '0;
            cnt       <= '0;
         end else if (do_shift) begin
            acc <= {acc_adj[ACC_W-2:0], sh[SCORE_W-1]};
            sh  <= sh << 1;
            cnt <= cnt + 1'b1;
         end
         if (do_load) disp <= sat ? NINES : acc[4*DIGITS-1:0];
      end
   end

   assign bus.busy      = busy_r;
   assign bus.fsm_state = state;

   // Leading-zero blanking; digit 0 always shows.
   logic [DIGITS-1:0] blank;
   logic              zero_above;

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
         blank[i]   = (BLANK_LZ != 0) && zero_above;
      end
   end

   logic [MUX_BITS-1:0] mux_cnt;
   logic [SEL_W-1:0]    sel;
   logic [DIGITS-1:0]   an_next;
   logic [7:0]          sseg_next;
   logic [DIGITS-1:0]   an_r;
   logic [7:0]          sseg_r;

   always_comb begin
      sel = mux_cnt[MUX_BITS-1 -: SEL_W];
      if (DIGITS == 1) sel = '0;
      an_next   = '1;
      sseg_next = 8'hFF;
      for (int i = 0; i < DIGITS; i++) begin
         if (sel == SEL_W'(i)) begin
            an_next[i] = 1'b0;
            sseg_next  = blank[i] ? 8'hFF : seg_code(disp[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mux_cnt <= '0;
         an_r    <= '1;
         sseg_r  <= 8'hFF;
      end else begin
         mux_cnt <= mux_cnt + 1'b1;
         an_r    <= an_next;
         sseg_r  <= sseg_next;
      end
   end

   assign bus.an   = an_r;
   assign bus.sseg = sseg_r;

   // Screen path: window/blank are delayed one stage to line up with the ROM read.
   logic [10:0] dx;
   logic [3:0]  row;
   logic        win;
   logic [3:0]  g_digit;
   logic        g_blank;
   logic [11:0] rom_addr;
   logic        rom_bit;
   logic        win_d;
   logic        blank_d;

   always_comb begin
      dx      = 11'(int'(bus.x) - X0);
      row     = 4'(int'(bus.y) - Y0);
      win     = (int'(bus.x) >= X0) && (int'(bus.x) < X0 + 16 * DIGITS) &&
                (int'(bus.y) >= Y0) && (int'(bus.y) < Y0 + 16);
      g_digit = 4'd0;
      g_blank = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (dx[10:4] == 7'(k)) begin
            g_digit = disp[4*(DIGITS-1-k) +: 4];
            g_blank = blank[DIGITS-1-k];
         end
      end
      rom_addr = {g_digit, row, dx[3:0]};
   end

   numbers_rom u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_d   <= 1'b0;
         blank_d <= 1'b1;
      end else begin
         win_d   <= win;
         blank_d <= g_blank;
      end
   end

   assign bus.score_on = rom_bit & win_d & ~blank_d;
endmodule
